adc_pair_sample_scheduler: RTL and testbench

- Captures decimated sample pairs from the two unsigned ADC channels (signal A, reference B) on a shared sample strobe.
- Converts each sample to two's complement and serialises A then B onto one valid/ready stream for the IQ demodulator.
- Sequences bursts of N pairs, or runs continuously, and counts overruns when the consumer stalls.

---
 rtl/adc_pair_sample_scheduler_pkg.sv | 26 ++
 rtl/adc_pair_sample_scheduler_offset.sv | 19 +
 rtl/adc_pair_sample_scheduler.sv | 131 +++++++++++++
 tb/tb_adc_pair_sample_scheduler.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pair_sample_scheduler_pkg.sv
// Shared types and constants for the ADC pair sample scheduler.
// Sample widths vary per instance, so the width-dependent constants are helper functions.
package adc_pair_sample_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        SEND_A = 3'd2,
        SEND_B = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    // Offset-binary midscale, 2^(n-1).
    function automatic logic [31:0] midscale(input int unsigned n);
        return 32'd1 << (n - 1);
    endfunction

    // Symmetric minimum {1,0..0,1}; raw code 0 maps here instead of to -2^(n-1).
    function automatic logic [31:0] sym_min(input int unsigned n);
        return midscale(n) | 32'd1;
    endfunction

endpackage

// File: rtl/adc_pair_sample_scheduler_offset.sv
// Converts an offset-binary ADC code to two's complement.
// Raw code 0 is clamped so that the signed range stays symmetric.
module adc_offset_to_twos
    import adc_pair_sample_scheduler_pkg::*;
#(
    parameter int N = 14
) (
    input  logic [N-1:0] raw,
    output logic [N-1:0] conv
);

    localparam logic [N-1:0] MID = N'(midscale(N));
    localparam logic [N-1:0] SYM = N'(sym_min(N));

    always_comb begin
        conv = (raw == '0) ? SYM : raw - MID;
    end

endmodule

// File: rtl/adc_pair_sample_scheduler.sv
// Captures decimated A/B ADC pairs and serialises them, A first, onto one valid/ready stream.
// Pairs are sent in bursts or continuously, and selected pairs are dropped and counted while the consumer stalls.
module adc_pair_sample_scheduler
    import adc_pair_sample_scheduler_pkg::*;
#(
    parameter int N     = 14,
    parameter int DEC_W = 8,
    parameter int LEN_W = 16,
    parameter int OVR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [DEC_W-1:0] dec_ratio,
    input  logic [LEN_W-1:0] burst_len,
    input  logic [N-1:0]     adc_a,
    input  logic [N-1:0]     adc_b,
    input  logic             adc_valid,
    output logic [N-1:0]     out_data,
    output logic             out_chan,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [OVR_W-1:0] overrun_cnt
);

    // state  | meaning
    // IDLE   | stopped, waiting for enable
    // WAIT   | running, waiting for a selected sample
    // SEND_A | presenting held A sample
    // SEND_B | presenting held B sample
    // DONE   | burst finished, waiting for enable to drop

    state_t           state_q, state_d;
    logic [DEC_W-1:0] dec_ratio_q, dec_cnt_q, dec_inc, dec_next;
    logic [LEN_W-1:0] burst_len_q, pair_cnt_q, pair_inc;
    logic [N-1:0]     hold_a_q, hold_b_q, conv_a, conv_b;
    logic [OVR_W-1:0] ovr_q;

    logic sending, selected, start, capture, dec_adv, overrun, pair_xfer, last_pair;

    adc_offset_to_twos #(.N(N)) u_conv_a (.raw(adc_a), .conv(conv_a));
    adc_offset_to_twos #(.N(N)) u_conv_b (.raw(adc_b), .conv(conv_b));

    always_comb begin
        sending   = (state_q == SEND_A) || (state_q == SEND_B);
        selected  = adc_valid && (dec_cnt_q == '0);
        start     = (state_q == IDLE) && enable;
        capture   = (state_q == WAIT) && enable && selected;
        dec_adv   = adc_valid && (((state_q == WAIT) && enable) || sending);
        overrun   = sending && selected;
        pair_xfer = (state_q == SEND_B) && out_ready;
        dec_inc   = dec_cnt_q + 1'b1;
        dec_next  = (dec_inc >= dec_ratio_q) ? '0 : dec_inc;
        pair_inc  = pair_cnt_q + 1'b1;
        last_pair = (burst_len_q != '0) && (pair_inc == burst_len_q);
    end

    always_comb begin
        state_d   = state_q;
        done      = 1'b0;
        out_valid = sending;
        out_chan  = (state_q == SEND_B) ? CH_B : CH_A;
        out_data  = '0;
        busy      = (state_q == WAIT) || sending;
        case (state_q)
            IDLE: begin
                if (enable) state_d = WAIT;
            end
            WAIT: begin
                if (!enable)       state_d = IDLE;
                else if (selected) state_d = SEND_A;
            end
            SEND_A: begin
                out_data = hold_a_q;
                if (out_ready) state_d = SEND_B;
            end
            SEND_B: begin
                out_data = hold_b_q;
                if (out_ready) begin
                    if (last_pair) begin
                        done    = 1'b1;
                        state_d = DONE;
                    end else if (!enable) begin
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            DONE: begin
                if (!enable) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dec_ratio_q <= '0;
            burst_len_q <= '0;
            dec_cnt_q   <= '0;
            pair_cnt_q  <= '0;
            hold_a_q    <= '0;
            hold_b_q    <= '0;
            ovr_q       <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                dec_ratio_q <= (dec_ratio == '0) ? DEC_W'(1) : dec_ratio;
                burst_len_q <= burst_len;
                dec_cnt_q   <= '0;
                pair_cnt_q  <= '0;
                ovr_q       <= '0;
            end else begin
                if (dec_adv) dec_cnt_q <= dec_next;
                if (capture) begin
                    hold_a_q <= conv_a;
                    hold_b_q <= conv_b;
                end
                if (overrun && (ovr_q != '1)) ovr_q <= ovr_q + 1'b1;
                if (pair_xfer) pair_cnt_q <= pair_inc;
            end
        end
    end

    assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_adc_pair_sample_scheduler.sv
// Scoreboard bench for adc_pair_sample_scheduler: stimulus pushes expected transfers,
// a negedge monitor pops and compares every accepted output word.
module tb_adc_pair_sample_scheduler;

    localparam int N     = 14;
    localparam int DEC_W = 8;
    localparam int LEN_W = 16;
    localparam int OVR_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic [DEC_W-1:0] dec_ratio;
    logic [LEN_W-1:0] burst_len;
    logic [N-1:0]     adc_a, adc_b;
    logic             adc_valid;
    logic [N-1:0]     out_data;
    logic             out_chan;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic [OVR_W-1:0] overrun_cnt;

    typedef struct packed {
        logic [N-1:0] data;
        logic         chan;
    } item_t;

    item_t sb[$];
    int tests = 0;
    int fails = 0;
    int xfers = 0;
    int done_pulses = 0;
    int done_bad = 0;
    int xfers_start;

    always #5 clk = ~clk;

    adc_pair_sample_scheduler #(.N(N), .DEC_W(DEC_W), .LEN_W(LEN_W), .OVR_W(OVR_W)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .dec_ratio(dec_ratio),
        .burst_len(burst_len), .adc_a(adc_a), .adc_b(adc_b), .adc_valid(adc_valid),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done), .overrun_cnt(overrun_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [N-1:0] a_exp, input logic [N-1:0] b_exp);
        sb.push_back('{data: a_exp, chan: 1'b0});
        sb.push_back('{data: b_exp, chan: 1'b1});
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
        check(name, sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                done_pulses++;
                if (!(out_valid && out_ready && out_chan)) done_bad++;
            end
            if (out_valid && out_ready) begin
                xfers++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_xfer actual=%h/%0d required=none", out_data, out_chan);
                end else begin
                    item_t e;
                    e = sb.pop_front();
                    check("xfer_data", out_data, e.data);
                    check("xfer_chan", out_chan, e.chan);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; enable = 0; dec_ratio = 1; burst_len = 0;
        adc_a = 0; adc_b = 0; adc_valid = 0; out_ready = 1;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovr", overrun_cnt, 0);
        check("rst_data", out_data, 0);
        check("rst_chan", out_chan, 0);
        @(posedge clk); #1 rst_n = 1;
        tick();

        // conversion, continuous, dec 1
        enable = 1;
        tick();
        check("busy_wait", busy, 1);
        adc_a = 14'h2000; adc_b = 14'h0000; adc_valid = 1;
        push_pair(14'h0000, 14'h2001);
        tick();
        adc_valid = 0;
        check("latency_valid", out_valid, 1);
        tick(); tick();
        adc_a = 14'h3FFF; adc_b = 14'h1FFF; adc_valid = 1;
        push_pair(14'h1FFF, 14'h3FFF);
        tick();
        adc_valid = 0;
        tick(); tick();
        adc_a = 14'h0001; adc_b = 14'h1234; adc_valid = 1;
        push_pair(14'h2001, 14'h3234);
        tick();
        adc_valid = 0;
        drain("conv_drain");
        enable = 0;
        tick(); tick();
        check("stop_idle", busy, 0);

        // decimation by 4, adc_valid every cycle
        dec_ratio = 4; enable = 1;
        tick();
        for (int k = 0; k < 12; k++) begin
            adc_a = 14'(14'h2000 + k); adc_b = 14'(14'h1000 + k); adc_valid = 1;
            if (k % 4 == 0) push_pair(14'(k), 14'(14'h3000 + k));
            tick();
        end
        adc_valid = 0;
        drain("dec4_drain");
        check("dec4_ovr", overrun_cnt, 0);
        enable = 0;
        tick(); tick();

        // dec_ratio 0 acts as 1: every valid selected
        dec_ratio = 0; enable = 1;
        tick();
        for (int k = 0; k < 6; k++) begin
            adc_a = 14'(14'h2100 + k); adc_b = 14'(14'h2200 + k); adc_valid = 1;
            if (k % 3 == 0) push_pair(14'(14'h0100 + k), 14'(14'h0200 + k));
            tick();
        end
        adc_valid = 0;
        drain("dec0_drain");
        check("dec0_ovr", overrun_cnt, 4);
        enable = 0;
        tick(); tick();

        // burst of 3 pairs, dec 3 matches the pair loop exactly
        burst_len = 3; dec_ratio = 3; enable = 1;
        tick();
        done_pulses = 0; done_bad = 0; xfers_start = xfers;
        for (int k = 0; k < 12; k++) begin
            adc_a = 14'(14'h2300 + k); adc_b = 14'(14'h2400 + k); adc_valid = 1;
            if (k % 3 == 0 && k < 9) push_pair(14'(14'h0300 + k), 14'(14'h0400 + k));
            tick();
        end
        adc_valid = 0;
        tick(); tick(); tick();
        check("burst_xfers", xfers - xfers_start, 6);
        check("burst_done_pulses", done_pulses, 1);
        check("burst_done_align", done_bad, 0);
        check("burst_busy", busy, 0);
        check("burst_out_valid", out_valid, 0);
        check("burst_ovr", overrun_cnt, 0);
        check("burst_sb_empty", sb.size(), 0);

        // backpressure 10 cycles in SEND_A, dec 2
        enable = 0;
        tick();
        burst_len = 0; dec_ratio = 2; out_ready = 0; enable = 1;
        tick();
        adc_a = 14'h2ABC; adc_b = 14'h0123; adc_valid = 1;
        push_pair(14'h0ABC, 14'h2123);
        tick();
        for (int i = 0; i < 10; i++) begin
            adc_a = 14'(14'h0100 + i); adc_b = 14'(14'h0200 + i); adc_valid = 1;
            tick();
            check("bp_data_stable", out_data, 14'h0ABC);
            check("bp_valid_held", {out_valid, out_chan}, 2'b10);
        end
        adc_valid = 0;
        check("bp_ovr", overrun_cnt, 5);
        out_ready = 1;
        drain("bp_drain");
        enable = 0;
        tick(); tick();
        enable = 1;
        tick();
        check("restart_ovr_clear", overrun_cnt, 0);

        // overrun saturation
        enable = 0;
        tick(); tick();
        dec_ratio = 1; out_ready = 0; enable = 1;
        tick();
        adc_a = 14'h3000; adc_b = 14'h1000; adc_valid = 1;
        push_pair(14'h1000, 14'h3000);
        tick();
        for (int i = 0; i < 600; i++) begin
            adc_a = 14'(i); adc_b = 14'(i + 7);
            tick();
        end
        adc_valid = 0;
        check("ovr_saturate", overrun_cnt, 255);
        out_ready = 1;
        drain("sat_drain");

        // enable dropped in SEND_A completes the pair, then IDLE
        out_ready = 0;
        adc_a = 14'h2055; adc_b = 14'h2066; adc_valid = 1;
        push_pair(14'h0055, 14'h0066);
        tick();
        adc_valid = 0; enable = 0;
        tick();
        check("stop_in_send_a", {out_valid, out_chan}, 2'b10);
        out_ready = 1;
        drain("stop_drain");
        tick();
        check("stop_then_idle", {busy, out_valid}, 2'b00);

        // async reset mid SEND_B
        enable = 1;
        tick();
        out_ready = 0;
        adc_a = 14'h2077; adc_b = 14'h2088; adc_valid = 1;
        sb.push_back('{data: 14'h0077, chan: 1'b0});
        tick();
        tick();
        adc_valid = 0; out_ready = 1;
        tick();
        out_ready = 0;
        check("pre_rst_send_b", {out_valid, out_chan}, 2'b11);
        check("pre_rst_ovr", overrun_cnt, 1);
        #2 rst_n = 0;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_chan", out_chan, 0);
        check("rst_mid_data", out_data, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_ovr", overrun_cnt, 0);
        check("final_sb_empty", sb.size(), 0);
        tick();
        rst_n = 1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
